// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops with N/Z/C/V flags,
// plus iterative shift-add MUL and restoring DIVU/REMU (one step per clock).
module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter int MULDIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [SH:0]      cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // x: MUL multiplicand (shifts left) / DIV dividend-becoming-quotient.
    // y: MUL multiplier (shifts right) / DIV divisor. acc: product / remainder.
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res, sra_res;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic             is_iter;
    logic [WIDTH-1:0] mul_acc, quo_nx, fin_res;
    logic [WIDTH:0]   rem_sh, rem_nx;
    logic             div_ge;

    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_res  = A - B;
    assign sra_res  = $unsigned($signed(A) >>> B[SH-1:0]);
    assign is_iter  = (MULDIV != 0) &&
                      (ALU_operation == OP_MUL || ALU_operation == OP_DIVU ||
                       ALU_operation == OP_REMU);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (ALU_operation)
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_res;
                sc_c   = (A >= B);
                sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  sc_res = A << B[SH-1:0];
            OP_SRL:  sc_res = A >> B[SH-1:0];
            OP_SRA:  sc_res = sra_res;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: sc_res = '0;
        endcase
    end

    // One iteration step; divide-by-zero falls out naturally (quotient all ones, remainder A).
    assign mul_acc = acc_q + (y_q[0] ? x_q : '0);
    assign rem_sh  = {acc_q, x_q[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, y_q});
    assign rem_nx  = div_ge ? (rem_sh - {1'b0, y_q}) : rem_sh;
    assign quo_nx  = {x_q[WIDTH-2:0], div_ge};
    assign fin_res = (op_q == OP_MUL)  ? mul_acc :
                     (op_q == OP_DIVU) ? quo_nx  : rem_nx[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = ALU_operation;
                    if (is_iter) begin
                        state_d = BUSY;
                        cnt_d   = (SH + 1)'(WIDTH);
                        x_d     = A;
                        y_d     = B;
                        acc_d   = '0;
                    end else begin
                        state_d  = DONE;
                        result_d = sc_res;
                        zero_d   = (sc_res == '0);
                        neg_d    = sc_res[WIDTH-1];
                        carry_d  = sc_c;
                        ovf_d    = sc_v;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - (SH + 1)'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = rem_nx[WIDTH-1:0];
                    x_d   = quo_nx;
                end
                if (cnt_q == (SH + 1)'(1)) begin
                    state_d  = DONE;
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    neg_d    = fin_res[WIDTH-1];
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign ALU_result = result_q;
    assign zero       = zero_q;
    assign negative   = neg_q;
    assign carry      = carry_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): arithmetic reference model with a
// scoreboard queue, a per-cycle compare process, and literal expectations on key vectors.
module tb_alu_multicycle;
    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, alu_result;
    logic [3:0]  op;
    logic        zero, negative, carry, overflow;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    alu_multicycle #(.WIDTH(32), .MULDIV(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .ALU_operation(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_result(alu_result),
        .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: plain integer arithmetic on the opcode table.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint sx, sy, s;
        longint unsigned u;
        sx = $signed(x);
        sy = $signed(y);
        e  = '0;
        case (o)
            4'b0000: e.r = x & y;
            4'b0001: e.r = x | y;
            4'b0011: e.r = x ^ y;
            4'b0010: begin
                u = longint'(x) + longint'(y);
                s = sx + sy;
                e.r = u[31:0];
                e.c = u[32];
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sx - sy;
                e.r = x - y;
                e.c = (x >= y);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100: e.r = x << y[4:0];
            4'b0101: e.r = x >> y[4:0];
            4'b1000: e.r = $unsigned($signed(x) >>> y[4:0]);
            4'b0111: e.r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1001: e.r = (x < y) ? 32'd1 : 32'd0;
            4'b1010: begin
                u = longint'(x) * longint'(y);
                e.r = u[31:0];
            end
            4'b1100: e.r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'b1101: e.r = (y == 0) ? x : x % y;
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    // Compare process: every cycle a result is presented it must match the oldest accepted op.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("scoreboard", 64'({alu_result, zero, negative, carry, overflow}),
                          64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Issue one op, measure latency (accept edge counts as 1), optionally stall in DONE.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_lat, input int hold, output exp_t got);
        int lat;
        bit busy_ok, hold_ok;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(o, x, y));
        #1;
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (exp_lat > 1) check("in_ready_low_busy", 64'(busy_ok), 64'd1);
        got = {alu_result, zero, negative, carry, overflow};
        if (hold > 0) begin
            hold_ok = 1'b1;
            in_valid = 1'b1;
            a = ~x; b = ~y; op = 4'b0010;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (in_ready || !out_valid) hold_ok = 1'b0;
            end
            check("hold_no_accept", 64'(hold_ok), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_handshake", 64'({in_ready, out_valid}), 64'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t g;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #2;
        check("reset_outputs", 64'({in_ready, out_valid, alu_result, zero, negative, carry, overflow}),
              64'({1'b1, 1'b0, 32'd0, 4'b0000}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Literal expectations pin both DUT and model; flags packed as z,n,c,v.
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 0, g);
        check("add_ovf", 64'(g), 64'({32'h8000_0000, 4'b0101}));
        run_op(4'b0110, 32'd5, 32'd5, 1, 0, g);
        check("sub_eq", 64'(g), 64'({32'd0, 4'b1010}));
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 0, g);
        check("slt", 64'(g), 64'({32'd1, 4'b0000}));
        run_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 1, 0, g);
        check("sltu", 64'(g), 64'({32'd0, 4'b1000}));
        run_op(4'b1000, 32'h8000_0000, 32'd4, 1, 0, g);
        check("sra", 64'(g), 64'({32'hF800_0000, 4'b0100}));
        run_op(4'b1010, 32'h0001_0001, 32'h0001_0001, 33, 0, g);
        check("mul", 64'(g), 64'({32'h0002_0001, 4'b0000}));
        run_op(4'b1100, 32'd100, 32'd7, 33, 0, g);
        check("divu", 64'(g), 64'({32'd14, 4'b0000}));
        run_op(4'b1101, 32'd100, 32'd7, 33, 0, g);
        check("remu", 64'(g), 64'({32'd2, 4'b0000}));
        run_op(4'b1100, 32'd9, 32'd0, 33, 0, g);
        check("divu_by0", 64'(g), 64'({32'hFFFF_FFFF, 4'b0100}));
        run_op(4'b1101, 32'd9, 32'd0, 33, 0, g);
        check("remu_by0", 64'(g), 64'({32'd9, 4'b0000}));
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 0, g);
        check("add_carry", 64'(g), 64'({32'd0, 4'b1010}));
        run_op(4'b0110, 32'd0, 32'd1, 1, 0, g);
        check("sub_borrow", 64'(g), 64'({32'hFFFF_FFFF, 4'b0100}));
        run_op(4'b0110, 32'h8000_0000, 32'd1, 1, 0, g);
        check("sub_ovf", 64'(g), 64'({32'h7FFF_FFFF, 4'b0011}));
        run_op(4'b1111, 32'h1234_5678, 32'd3, 1, 0, g);
        check("undef_op", 64'(g), 64'({32'd0, 4'b1000}));

        // Further patterns checked by the scoreboard only.
        run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 0, g);
        run_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 1, 0, g);
        run_op(4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 1, 0, g);
        run_op(4'b0100, 32'h0000_0001, 32'd31, 1, 0, g);
        run_op(4'b0101, 32'h8000_0000, 32'h0000_0023, 1, 0, g);
        run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, g);
        run_op(4'b1100, 32'hDEAD_BEEF, 32'h0000_1234, 33, 0, g);
        run_op(4'b1101, 32'hDEAD_BEEF, 32'h0000_1234, 33, 0, g);

        // Stall in DONE for 5 clocks with a new request pending.
        run_op(4'b0010, 32'd1, 32'd1, 1, 5, g);
        check("add_held", 64'(g), 64'({32'd2, 4'b0000}));

        // Reset during MUL at BUSY cycle 10; the in-flight op is dropped.
        @(negedge clk);
        op = 4'b1010; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid_busy", 64'({in_ready, out_valid, alu_result, zero, negative, carry, overflow}),
              64'({1'b1, 1'b0, 32'd0, 4'b0000}));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_op(4'b0010, 32'd2, 32'd3, 1, 0, g);
        check("add_after_reset", 64'(g), 64'({32'd5, 4'b0000}));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
